campo_controle: RTL and testbench
=================================

Name: campo_controle

Overview:
- Minesweeper board controller; sits directly downstream of the switch edge detector.
- Consumes its one-cycle abertura (open) and bandeira (flag) pulses, together with the current cursor position.
- Maintains per-cell opened/flagged state and neighbour-mine counts, and detects win/loss.
- Outputs feed the VGA renderer and the HEX/LED status logic.

Parameters:
- LINHAS, 8, board rows
- COLUNAS, 8, board columns
- NUM_MINAS, 10, mines on board; used for the win condition and the optional flag limit

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; the top level drives it from ~SW[9]
- abertura  in  1  one-cycle open request pulse
- bandeira  in  1  one-cycle flag-toggle request pulse
- cursor_linha  in  $clog2(LINHAS)  cursor row, sampled with the pulse
- cursor_coluna  in  $clog2(COLUNAS)  cursor column, sampled with the pulse
- minas  in  LINHAS*COLUNAS  mine map, bit r*COLUNAS+c; stable while reset is high
- abertas  out  LINHAS*COLUNAS  opened cells
- bandeiras  out  LINHAS*COLUNAS  flagged cells
- vizinhos  out  4*LINHAS*COLUNAS  neighbour count per opened cell, nibble r*COLUNAS+c
- num_bandeiras  out  $clog2(LINHAS*COLUNAS+1)  flags placed
- ocupado  out  1  FSM not in OCIOSO
- perdeu  out  1  sticky: a mine was opened
- venceu  out  1  sticky: all safe cells opened

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0, including abertas, bandeiras, vizinhos and the counters.
  - Pending latches are cleared and the FSM returns to OCIOSO.
  - Reset mid-scan aborts the operation; nothing is written.
- Pending latches:
  - An abertura pulse sets pend_a and captures pos_a = cursor position on the same edge.
  - bandeira does the same with pend_b and pos_b.
  - A pulse arriving while its own latch is already set is dropped; the stored position is kept.
  - Both pulses arriving in the same cycle set both latches.
- FSM states: OCIOSO, CHECA, VARRE, ESCREVE, PERDIDO, VENCIDO.
- OCIOSO:
  - If pend_a: clear pend_a, load the cell index, go to CHECA. pend_a has priority; pend_b waits.
  - Else if pend_b: clear pend_b; if the cell is not opened, toggle its flag and do num_bandeiras ±1. Stay in OCIOSO.
- CHECA:
  - Cell already opened or flagged: go to OCIOSO (no-op).
  - Cell is a mine: go to PERDIDO.
  - Otherwise clear the 3-bit neighbour counter k and the count register, then go to VARRE.
- VARRE:
  - One neighbour per cycle, k = 0..7, in order NW, N, NE, W, E, SW, S, SE.
  - Out-of-board neighbours (row/column underflow or ≥ limit) contribute 0; no wrap-around.
  - After k=7 go to ESCREVE.
- ESCREVE:
  - Set the opened bit, write the count nibble (0..8), increment the opened counter.
  - If opened == LINHAS*COLUNAS − NUM_MINAS go to VENCIDO, else OCIOSO.
- PERDIDO / VENCIDO:
  - Terminal states; perdeu/venceu are driven high.
  - All further pulses are ignored; the latches stay cleared. Only reset exits.
- Latency, counting pulse edge as E0:
  - Flag toggle is visible after E1.
  - Safe open is visible after E11 (E1 CHECA, E2 VARRE start, E10 last scan, E11 ESCREVE).
  - Mine open: perdeu is high after E2.
- ocupado = 1 in CHECA, VARRE and ESCREVE.
- Flag count never underflows; removing a flag is only possible on a flagged cell.

Optional Feature:
- Macro: CAMPO_LIMITE_BANDEIRAS_EN.
- Defined: a flag-set request is ignored when num_bandeiras == NUM_MINAS; flag removal is always allowed.
- Undefined: unlimited flags, up to the number of unopened cells.

Decomposition:
- Package campo_pkg holds:
  - the default board dimensions and NUM_MINAS;
  - the FSM state enum;
  - the neighbour offset table (8 signed row/column deltas);
  - the cell-index width helper.
- One natural sub-module: campo_vizinho. It is combinational: given row, column and k, it returns the neighbour index plus a valid flag, handling the board edges.

Test Plan:
- Mine at (0,1) only; open (0,0) → abertas[0]=1 after 11 cycles; vizinhos[3:0]=1; perdeu=0.
- Corner (7,7) with mines at (6,6),(6,7),(7,6) → count 3; no wrap to row 0 or column 0.
- Flag (2,2), then open (2,2) → open ignored, abertas bit stays 0; flag again → bandeiras bit cleared, num_bandeiras back to 0.
- abertura and bandeira in the same cycle on different cells → open completes first, then the flag is set; both visible, ocupado drops after the open.
- Open a mine cell → perdeu=1 at E2; later pulses change nothing; reset low mid-VARRE → all outputs 0 immediately.
- NUM_MINAS=1, 63 safe opens → venceu=1 after the last ESCREVE. With CAMPO_LIMITE_BANDEIRAS_EN, a second flag is rejected and num_bandeiras stays at 1.

Source files
------------

// File: rtl/campo_controle_pkg.sv
// Minesweeper board controller: shared types and constants.
// Default board geometry, FSM state encoding, neighbour offset table
// (scan order NW, N, NE, W, E, SW, S, SE) and the index-width helper.
package campo_pkg;

  localparam int LINHAS_PAD    = 8;
  localparam int COLUNAS_PAD   = 8;
  localparam int NUM_MINAS_PAD = 10;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CHECA   = 3'd1,
    VARRE   = 3'd2,
    ESCREVE = 3'd3,
    PERDIDO = 3'd4,
    VENCIDO = 3'd5
  } estado_t;

  typedef logic signed [1:0] delta_t;

  localparam delta_t DELTA_LINHA [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam delta_t DELTA_COLUNA[8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};

  // Width of an index able to address n items (at least one bit).
  function automatic int largura_idx(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/campo_controle_if.sv
// Board controller bus: request pulses and cursor from the edge detector,
// mine map, and the board/status outputs consumed by VGA and HEX/LED logic.
interface campo_controle_if
  import campo_pkg::*;
#(
  parameter int LINHAS  = LINHAS_PAD,
  parameter int COLUNAS = COLUNAS_PAD
);
  localparam int LW  = largura_idx(LINHAS);
  localparam int CW  = largura_idx(COLUNAS);
  localparam int N   = LINHAS * COLUNAS;
  localparam int NBW = $clog2(N + 1);

  logic            abertura;
  logic            bandeira;
  logic [LW-1:0]   cursor_linha;
  logic [CW-1:0]   cursor_coluna;
  logic [N-1:0]    minas;
  logic [N-1:0]    abertas;
  logic [N-1:0]    bandeiras;
  logic [4*N-1:0]  vizinhos;
  logic [NBW-1:0]  num_bandeiras;
  logic            ocupado;
  logic            perdeu;
  logic            venceu;

  modport slave (
    input  abertura, bandeira, cursor_linha, cursor_coluna, minas,
    output abertas, bandeiras, vizinhos, num_bandeiras, ocupado, perdeu, venceu
  );

  modport master (
    output abertura, bandeira, cursor_linha, cursor_coluna, minas,
    input  abertas, bandeiras, vizinhos, num_bandeiras, ocupado, perdeu, venceu
  );

endinterface

// File: rtl/campo_controle_vizinho.sv
// Neighbour address generator: for cell (linha, coluna) and scan step k,
// returns the flat index of the k-th neighbour and whether it lies on the
// board. Off-board neighbours never wrap to the opposite edge.
module campo_vizinho
  import campo_pkg::*;
#(
  parameter int LINHAS  = LINHAS_PAD,
  parameter int COLUNAS = COLUNAS_PAD
) (
  input  logic [largura_idx(LINHAS)-1:0]           linha,
  input  logic [largura_idx(COLUNAS)-1:0]          coluna,
  input  logic [2:0]                               k,
  output logic [largura_idx(LINHAS*COLUNAS)-1:0]   idx,
  output logic                                     valido
);
  localparam int IW = largura_idx(LINHAS * COLUNAS);

  int lin_viz_s;
  int col_viz_s;

  // Signed row/column arithmetic so underflow shows up as a negative value.
  always_comb begin
    lin_viz_s = int'(linha) + int'(DELTA_LINHA[k]);
    col_viz_s = int'(coluna) + int'(DELTA_COLUNA[k]);
    valido    = (lin_viz_s >= 32'sd0) && (lin_viz_s < LINHAS) &&
                (col_viz_s >= 32'sd0) && (col_viz_s < COLUNAS);
    if (valido) begin
      idx = IW'(lin_viz_s * COLUNAS + col_viz_s);
    end else begin
      idx = '0;
    end
  end

endmodule

// File: rtl/campo_controle.sv
// Minesweeper board controller. Latches open/flag pulses, scans the eight
// neighbours of an opened cell one per cycle, and tracks win/loss.
// Optional build macro: CAMPO_LIMITE_BANDEIRAS_EN limits placed flags to NUM_MINAS.
module campo_controle
  import campo_pkg::*;
#(
  parameter int LINHAS    = LINHAS_PAD,
  parameter int COLUNAS   = COLUNAS_PAD,
  parameter int NUM_MINAS = NUM_MINAS_PAD
) (
  input logic             clk,
  input logic             reset,
  campo_controle_if.slave bus
);
  localparam int LW      = largura_idx(LINHAS);
  localparam int CW      = largura_idx(COLUNAS);
  localparam int N       = LINHAS * COLUNAS;
  localparam int IW      = largura_idx(N);
  localparam int NBW     = $clog2(N + 1);
  localparam int SEGUROS = N - NUM_MINAS;

  estado_t        estado_r, estado_next_s;
  logic           pend_a_r, pend_b_r;
  logic [LW-1:0]  pos_a_lin_r, pos_b_lin_r, lin_r;
  logic [CW-1:0]  pos_a_col_r, pos_b_col_r, col_r;
  logic [2:0]     k_r;
  logic [3:0]     cont_r;
  logic [N-1:0]   abertas_r, bandeiras_r;
  logic [4*N-1:0] vizinhos_r;
  logic [NBW-1:0] num_band_r, num_abertas_r;
  logic           ocupado_r, perdeu_r, venceu_r;

  logic [IW-1:0]  idx_cel_s, idx_b_s, viz_idx_s;
  logic           viz_valido_s;
  logic           carrega_s, trata_b_s, limpa_s, soma_s, escreve_s, alterna_s;

  assign idx_cel_s = IW'(int'(lin_r) * COLUNAS + int'(col_r));
  assign idx_b_s   = IW'(int'(pos_b_lin_r) * COLUNAS + int'(pos_b_col_r));

  campo_vizinho #(.LINHAS(LINHAS), .COLUNAS(COLUNAS)) u_vizinho (
    .linha  (lin_r),
    .coluna (col_r),
    .k      (k_r),
    .idx    (viz_idx_s),
    .valido (viz_valido_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado_r <= OCIOSO;
    else        estado_r <= estado_next_s;
  end

  // Next-state logic.
  always_comb begin
    estado_next_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (pend_a_r) estado_next_s = CHECA;
        else          estado_next_s = OCIOSO;
      end
      CHECA: begin
        if (abertas_r[idx_cel_s] || bandeiras_r[idx_cel_s]) estado_next_s = OCIOSO;
        else if (bus.minas[idx_cel_s])                      estado_next_s = PERDIDO;
        else                                                estado_next_s = VARRE;
      end
      VARRE: begin
        if (k_r == 3'd7) estado_next_s = ESCREVE;
        else             estado_next_s = VARRE;
      end
      ESCREVE: begin
        if (num_abertas_r + NBW'(1) == NBW'(SEGUROS)) estado_next_s = VENCIDO;
        else                                          estado_next_s = OCIOSO;
      end
      PERDIDO: estado_next_s = PERDIDO;
      VENCIDO: estado_next_s = VENCIDO;
      default: estado_next_s = OCIOSO;
    endcase
  end

  // Per-state datapath controls; pend_a wins over pend_b in OCIOSO.
  always_comb begin
    carrega_s = 1'b0;
    trata_b_s = 1'b0;
    limpa_s   = 1'b0;
    soma_s    = 1'b0;
    escreve_s = 1'b0;
    case (estado_r)
      OCIOSO: begin
        carrega_s = pend_a_r;
        trata_b_s = !pend_a_r && pend_b_r;
      end
      CHECA:   limpa_s   = (estado_next_s == VARRE);
      VARRE:   soma_s    = 1'b1;
      ESCREVE: escreve_s = 1'b1;
      default: carrega_s = 1'b0;
    endcase
  end

  // Flag toggle decision: never on an opened cell, optionally capped when setting.
  always_comb begin
    alterna_s = 1'b0;
    if (trata_b_s && !abertas_r[idx_b_s]) begin
`ifdef CAMPO_LIMITE_BANDEIRAS_EN
      if (!bandeiras_r[idx_b_s] && (num_band_r == NBW'(NUM_MINAS))) alterna_s = 1'b0;
      else                                                          alterna_s = 1'b1;
`else
      alterna_s = 1'b1;
`endif
    end else begin
      alterna_s = 1'b0;
    end
  end

  // Pending request latches; a pulse hitting an already-set latch is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_a_r    <= 1'b0;
      pend_b_r    <= 1'b0;
      pos_a_lin_r <= '0;
      pos_a_col_r <= '0;
      pos_b_lin_r <= '0;
      pos_b_col_r <= '0;
    end else if (estado_next_s == PERDIDO || estado_next_s == VENCIDO) begin
      pend_a_r <= 1'b0;
      pend_b_r <= 1'b0;
    end else begin
      if (carrega_s) begin
        pend_a_r <= 1'b0;
      end else if (!pend_a_r && bus.abertura) begin
        pend_a_r    <= 1'b1;
        pos_a_lin_r <= bus.cursor_linha;
        pos_a_col_r <= bus.cursor_coluna;
      end
      if (trata_b_s) begin
        pend_b_r <= 1'b0;
      end else if (!pend_b_r && bus.bandeira) begin
        pend_b_r    <= 1'b1;
        pos_b_lin_r <= bus.cursor_linha;
        pos_b_col_r <= bus.cursor_coluna;
      end
    end
  end

  // Board state: cell load, neighbour scan, cell write and flag toggling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lin_r         <= '0;
      col_r         <= '0;
      k_r           <= 3'd0;
      cont_r        <= 4'd0;
      abertas_r     <= '0;
      bandeiras_r   <= '0;
      vizinhos_r    <= '0;
      num_band_r    <= '0;
      num_abertas_r <= '0;
    end else begin
      if (carrega_s) begin
        lin_r <= pos_a_lin_r;
        col_r <= pos_a_col_r;
      end
      if (limpa_s) begin
        k_r    <= 3'd0;
        cont_r <= 4'd0;
      end else if (soma_s) begin
        k_r    <= k_r + 3'd1;
        cont_r <= cont_r + {3'd0, viz_valido_s & bus.minas[viz_idx_s]};
      end
      if (escreve_s) begin
        abertas_r[idx_cel_s]               <= 1'b1;
        vizinhos_r[{idx_cel_s, 2'b00} +: 4] <= cont_r;
        num_abertas_r                      <= num_abertas_r + NBW'(1);
      end
      if (alterna_s) begin
        bandeiras_r[idx_b_s] <= ~bandeiras_r[idx_b_s];
        if (bandeiras_r[idx_b_s]) num_band_r <= num_band_r - NBW'(1);
        else                      num_band_r <= num_band_r + NBW'(1);
      end
    end
  end

  // Registered status flags taken from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocupado_r <= 1'b0;
      perdeu_r  <= 1'b0;
      venceu_r  <= 1'b0;
    end else begin
      ocupado_r <= (estado_next_s == CHECA) || (estado_next_s == VARRE) ||
                   (estado_next_s == ESCREVE);
      perdeu_r  <= (estado_next_s == PERDIDO);
      venceu_r  <= (estado_next_s == VENCIDO);
    end
  end

  assign bus.abertas       = abertas_r;
  assign bus.bandeiras     = bandeiras_r;
  assign bus.vizinhos      = vizinhos_r;
  assign bus.num_bandeiras = num_band_r;
  assign bus.ocupado       = ocupado_r;
  assign bus.perdeu        = perdeu_r;
  assign bus.venceu        = venceu_r;

endmodule

// File: tb/tb_campo_controle.sv
// Directed bench for campo_controle on an 8x8 board with 10 mines.
module tb_campo_controle;

`ifdef CAMPO_LIMITE_BANDEIRAS_EN
  localparam bit LIMITE = 1'b1;
`else
  localparam bit LIMITE = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [63:0]  esp_ab, esp_band, m1, m2;
  logic [255:0] esp_viz;
  int           esp_num;
  int           n_abertas;

  campo_controle_if #(.LINHAS(8), .COLUNAS(8)) bus ();

  campo_controle #(.LINHAS(8), .COLUNAS(8), .NUM_MINAS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [255:0] obs, input logic [255:0] esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // One-cycle pulse(s) with the cursor at (lin, col); returns at the negedge after E0.
  task automatic pulso(input logic a, input logic b, input int lin, input int col);
    @(negedge clk);
    bus.abertura      = a;
    bus.bandeira      = b;
    bus.cursor_linha  = 3'(lin);
    bus.cursor_coluna = 3'(col);
    @(negedge clk);
    bus.abertura = 1'b0;
    bus.bandeira = 1'b0;
  endtask

  task automatic abre(input int lin, input int col);
    pulso(1'b1, 1'b0, lin, col);
    repeat (11) @(negedge clk);
  endtask

  task automatic marca(input int lin, input int col);
    pulso(1'b0, 1'b1, lin, col);
    @(negedge clk);
  endtask

  task automatic aplica_reset(input logic [63:0] m);
    reset     = 1'b0;
    bus.minas = m;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    esp_ab   = '0;
    esp_band = '0;
    esp_viz  = '0;
    esp_num  = 0;
  endtask

  task automatic verifica_zero(input string tag);
    verifica({tag, "_abertas"}, bus.abertas, 256'd0);
    verifica({tag, "_bandeiras"}, bus.bandeiras, 256'd0);
    verifica({tag, "_vizinhos"}, bus.vizinhos, 256'd0);
    verifica({tag, "_num"}, bus.num_bandeiras, 256'd0);
    verifica({tag, "_ocupado"}, bus.ocupado, 256'd0);
    verifica({tag, "_perdeu"}, bus.perdeu, 256'd0);
    verifica({tag, "_venceu"}, bus.venceu, 256'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.abertura = 1'b0;
    bus.bandeira = 1'b0;
    bus.cursor_linha = 3'd0;
    bus.cursor_coluna = 3'd0;
    m1 = 64'd0;
    m1[6] = 1'b1; m1[7] = 1'b1; m1[48] = 1'b1; m1[54] = 1'b1;
    m1[55] = 1'b1; m1[56] = 1'b1; m1[62] = 1'b1;
    m2 = m1;
    m2[20] = 1'b1; m2[30] = 1'b1; m2[40] = 1'b1;

    // Reset state, single mine at (0,1).
    reset = 1'b0;
    bus.minas = 64'h2;
    repeat (2) @(negedge clk);
    verifica_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // Open (0,0): busy after E1, not yet written after E10, written after E11.
    pulso(1'b1, 1'b0, 0, 0);
    @(negedge clk);
    verifica("abre00_ocupado_e1", bus.ocupado, 256'd1);
    repeat (9) @(negedge clk);
    verifica("abre00_e10", bus.abertas[0], 256'd0);
    @(negedge clk);
    verifica("abre00_e11", bus.abertas, 256'h1);
    verifica("abre00_viz", bus.vizinhos, 256'h1);
    verifica("abre00_perdeu", bus.perdeu, 256'd0);
    verifica("abre00_ocupado", bus.ocupado, 256'd0);

    // Edge/corner counts with mines placed where a wrap-around would be seen.
    aplica_reset(m1);
    abre(7, 7);
    esp_ab[63] = 1'b1; esp_viz[255:252] = 4'd3;
    verifica("canto77_ab", bus.abertas, esp_ab);
    verifica("canto77_viz", bus.vizinhos, esp_viz);
    abre(0, 0);
    esp_ab[0] = 1'b1;
    verifica("canto00_ab", bus.abertas, esp_ab);
    verifica("canto00_viz", bus.vizinhos, esp_viz);
    abre(7, 5);
    esp_ab[61] = 1'b1; esp_viz[247:244] = 4'd2;
    verifica("borda75_viz", bus.vizinhos, esp_viz);

    // Flag (2,2), blocked open, unflag, flag on an opened cell.
    marca(2, 2);
    verifica("flag22_band", bus.bandeiras, 256'd1 << 18);
    verifica("flag22_num", bus.num_bandeiras, 256'd1);
    abre(2, 2);
    verifica("flag22_abre_bloq", bus.abertas, esp_ab);
    marca(2, 2);
    verifica("unflag22_band", bus.bandeiras, 256'd0);
    verifica("unflag22_num", bus.num_bandeiras, 256'd0);
    marca(7, 7);
    verifica("flag_aberta_num", bus.num_bandeiras, 256'd0);

    // Same-cycle open+flag on one cell: open first, flag then dropped (cell opened).
    pulso(1'b1, 1'b1, 3, 3);
    @(negedge clk);
    verifica("dupla_band_e1", bus.bandeiras, 256'd0);
    repeat (10) @(negedge clk);
    esp_ab[27] = 1'b1;
    verifica("dupla_ab_e11", bus.abertas, esp_ab);
    @(negedge clk);
    verifica("dupla_band_e12", bus.bandeiras, 256'd0);

    // Flag on another cell requested while an open is in flight waits for it.
    pulso(1'b1, 1'b0, 4, 4);
    repeat (2) @(negedge clk);
    pulso(1'b0, 1'b1, 2, 5);
    repeat (7) @(negedge clk);
    esp_ab[36] = 1'b1;
    verifica("espera_ab_e11", bus.abertas, esp_ab);
    verifica("espera_ocupado_e11", bus.ocupado, 256'd0);
    verifica("espera_band_e11", bus.bandeiras, 256'd0);
    @(negedge clk);
    esp_band[21] = 1'b1; esp_num = 1;
    verifica("espera_band_e12", bus.bandeiras, esp_band);
    verifica("espera_viz", bus.vizinhos, esp_viz);

    // Flag many cells: capped at NUM_MINAS only with the limit enabled.
    for (int i = 40; i < 50; i++) begin
      marca(i / 8, i % 8);
      if (!LIMITE || esp_num < 10) begin
        esp_band[i] = 1'b1;
        esp_num++;
      end
    end
    verifica("limite_num", bus.num_bandeiras, 256'(esp_num));
    verifica("limite_band", bus.bandeiras, esp_band);
    marca(5, 0);
    esp_band[40] = 1'b0; esp_num--;
    verifica("remove_num", bus.num_bandeiras, 256'(esp_num));

    // Open a mine: perdeu after E2, then everything frozen.
    pulso(1'b1, 1'b0, 0, 6);
    @(negedge clk);
    verifica("mina_perdeu_e1", bus.perdeu, 256'd0);
    @(negedge clk);
    verifica("mina_perdeu_e2", bus.perdeu, 256'd1);
    verifica("mina_ocupado_e2", bus.ocupado, 256'd0);
    marca(1, 1);
    abre(1, 1);
    verifica("morto_ab", bus.abertas, esp_ab);
    verifica("morto_band", bus.bandeiras, esp_band);
    verifica("morto_num", bus.num_bandeiras, 256'(esp_num));
    verifica("morto_perdeu", bus.perdeu, 256'd1);

    // Reset asserted mid-scan clears everything at once and writes nothing.
    aplica_reset(m1);
    abre(0, 0);
    marca(2, 2);
    pulso(1'b1, 1'b0, 1, 1);
    repeat (4) @(negedge clk);
    verifica("meio_ocupado", bus.ocupado, 256'd1);
    reset = 1'b0;
    #1;
    verifica_zero("meio_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    verifica("meio_pos_ab", bus.abertas, 256'd0);
    verifica("meio_pos_ocupado", bus.ocupado, 256'd0);

    // Win: open all 54 safe cells.
    aplica_reset(m2);
    n_abertas = 0;
    for (int i = 0; i < 64; i++) begin
      if (!m2[i]) begin
        if (n_abertas == 53) verifica("vence_antes", bus.venceu, 256'd0);
        abre(i / 8, i % 8);
        n_abertas++;
      end
    end
    verifica("vence_venceu", bus.venceu, 256'd1);
    verifica("vence_ab", bus.abertas, {192'd0, ~m2});
    verifica("vence_ocupado", bus.ocupado, 256'd0);
    abre(0, 6);
    verifica("vence_mina_ign", bus.perdeu, 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
